// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings and the SRAM slave FSM state type.
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

endpackage

// File: rtl/ahb3lite_byte_lane_dec.sv
// Little-endian byte-lane enables from transfer size and the low address bits.
// Sizes above a word are treated as a word; misaligned offsets align down.
module ahb3lite_byte_lane_dec
  import ahb3lite_pkg::*;
#(
  parameter  int HDATA_SIZE = 32,
  localparam int LANES      = HDATA_SIZE / 8,
  localparam int OFS_W      = $clog2(LANES)
) (
  input  logic [2:0]       size,
  input  logic [OFS_W-1:0] offset,
  output logic [LANES-1:0] be
);

  logic [2:0] sz_eff;
  int         nbytes;
  int         base;

  // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    sz_eff = (size > HSIZE_WORD) ? HSIZE_WORD : size;
    nbytes = 1 << sz_eff;
    if (nbytes > LANES) nbytes = LANES;
    base = (int'(offset) / nbytes) * nbytes;
    be   = '0;
    for (int i = 0; i < LANES; i++) begin
      be[i] = (i >= base) && (i < base + nbytes);
    end
  end

endmodule

// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite SRAM slave: flop word array, programmable wait states, byte-lane writes.
// Define AHB_SRAM_ERROR_EN to return ERROR for out-of-range, misaligned and oversized transfers.
module ahb3lite_sram_slave
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic [HDATA_SIZE-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int LANES    = HDATA_SIZE / 8;
  localparam int ADDR_LSB = $clog2(LANES);
  localparam int IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int WADDR_W  = HADDR_SIZE - ADDR_LSB;

  logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

  state_t                state, state_nxt, accept_state;
  logic [3:0]            wait_cnt;
  logic [IDX_W-1:0]      idx_q, idx_in;
  logic [ADDR_LSB-1:0]   ofs_q;
  logic                  write_q;
  logic [2:0]            size_q;
  logic [HDATA_SIZE-1:0] rdata_q;
  logic [LANES-1:0]      be;
  logic [WADDR_W-1:0]    word_addr;
  logic                  accept, take, xfer_err;

  // Burst type and protection carry no meaning for a flat memory.
  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HPROT};

  assign accept    = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign take      = accept && (state == ST_IDLE || state == ST_DATA || state == ST_ERR2);
  assign word_addr = HADDR[HADDR_SIZE-1:ADDR_LSB];

`ifdef AHB_SRAM_ERROR_EN
  logic misaligned, out_of_range;
  assign out_of_range = word_addr >= WADDR_W'(MEM_DEPTH);
  assign misaligned   = (HSIZE == HSIZE_HALF && HADDR[0])
                     || (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00)
                     || (HSIZE > HSIZE_WORD);
  assign xfer_err     = misaligned || out_of_range;
  assign idx_in       = word_addr[IDX_W-1:0];
`else
  assign xfer_err     = 1'b0;
  assign idx_in       = IDX_W'(word_addr % WADDR_W'(MEM_DEPTH));
`endif

  assign accept_state = xfer_err          ? ST_ERR1 :
                        (WAIT_STATES > 0) ? ST_WAIT : ST_DATA;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_WAIT: if (wait_cnt == 4'd1) state_nxt = ST_DATA;
`ifdef AHB_SRAM_ERROR_EN
      ST_ERR1: state_nxt = ST_ERR2;
`endif
      default: state_nxt = take ? accept_state : ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      HREADYOUT <= 1'b1;
      rdata_q   <= '0;
      idx_q     <= '0;
      ofs_q     <= '0;
      write_q   <= 1'b0;
      size_q    <= HSIZE_BYTE;
    end else begin
      state     <= state_nxt;
      HREADYOUT <= (state_nxt != ST_WAIT) && (state_nxt != ST_ERR1);
      if (state_nxt == ST_WAIT)
        wait_cnt <= (state == ST_WAIT) ? wait_cnt - 4'd1 : 4'(WAIT_STATES);
      else
        wait_cnt <= '0;
      if (state == ST_DATA && !write_q) rdata_q <= mem[idx_q];
      if (take) begin
        idx_q   <= idx_in;
        ofs_q   <= HADDR[ADDR_LSB-1:0];
        write_q <= HWRITE;
        size_q  <= HSIZE;
      end
    end
  end

`ifdef AHB_SRAM_ERROR_EN
  logic resp_q;
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) resp_q <= HRESP_OKAY;
    else          resp_q <= (state_nxt == ST_ERR1 || state_nxt == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  end
  assign HRESP = resp_q;
`else
  assign HRESP = HRESP_OKAY;
`endif

  ahb3lite_byte_lane_dec #(.HDATA_SIZE(HDATA_SIZE)) u_lane_dec (
    .size   (size_q),
    .offset (ofs_q),
    .be     (be)
  );

  // NOTE: the array has no reset; its contents are undefined until written, like a real SRAM.
  always_ff @(posedge HCLK) begin
    if (state == ST_DATA && write_q) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  // Reads are served from the array during DATA; otherwise the last read word is held.
  assign HRDATA = (state == ST_DATA && !write_q) ? mem[idx_q] : rdata_q;

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Scoreboard bench: two slaves (0 and 3 wait states) driven in turn by one pipelined master.
module tb_ahb3lite_sram_slave;
  import ahb3lite_pkg::*;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    bit          resp;
    int          waits;
    string       name;
  } exp_t;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic        hsel_cmd = 1'b0;
  logic        dut_sel = 1'b0;
  logic [31:0] haddr = '0;
  logic [31:0] hwdata = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = HSIZE_WORD;
  logic [1:0]  htrans = HTRANS_IDLE;

  logic [31:0] hrdata0, hrdata1;
  logic        hro0, hro1, hresp0, hresp1;
  logic        m_rdy, m_resp;
  logic [31:0] m_rdata;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 HCLK = ~HCLK;

  assign m_rdy   = dut_sel ? hro1    : hro0;
  assign m_resp  = dut_sel ? hresp1  : hresp0;
  assign m_rdata = dut_sel ? hrdata1 : hrdata0;

  ahb3lite_sram_slave #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(64), .WAIT_STATES(0)) u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel_cmd && !dut_sel), .HADDR(haddr),
    .HWDATA(hwdata), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011),
    .HTRANS(htrans), .HREADY(hro0), .HRDATA(hrdata0), .HREADYOUT(hro0), .HRESP(hresp0)
  );

  ahb3lite_sram_slave #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(64), .WAIT_STATES(3)) u_dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel_cmd && dut_sel), .HADDR(haddr),
    .HWDATA(hwdata), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b001), .HPROT(4'b0011),
    .HTRANS(htrans), .HREADY(hro1), .HRDATA(hrdata1), .HREADYOUT(hro1), .HRESP(hresp1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge HCLK);
    #1;
  endtask

  // Drives one address phase; returns just after the edge that accepts it, with HWDATA set.
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, input logic [31:0] rexp,
                       input bit err, input bit push, input string name);
    exp_t e;
    int   n;
    bit   r;
    e.rd    = !wr;
    e.data  = rexp;
    e.resp  = err;
    e.waits = err ? 1 : (dut_sel ? 3 : 0);
    e.name  = name;
    if (push) sb.push_back(e);
    hsel_cmd = 1'b1;
    htrans   = HTRANS_NONSEQ;
    haddr    = addr;
    hwrite   = wr;
    hsize    = size;
    n = 0;
    r = 1'b0;
    while (!r && n < 64) begin
      @(negedge HCLK);
      r = m_rdy;
      @(posedge HCLK);
      n++;
    end
    #1;
    if (!r) begin
      tests++;
      fails++;
      $display("FAIL %s_accept: address phase not accepted after %0d cycles", name, n);
    end
    hwdata   = wdata;
    hsel_cmd = 1'b0;
    htrans   = HTRANS_IDLE;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge HCLK);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
    sync();
  endtask

  // Monitor: tracks data phases on the selected slave and scores each completion.
  initial begin : monitor
    bit   dp;
    bit   bad;
    int   nwait;
    exp_t e;
    dp = 1'b0; bad = 1'b0; nwait = 0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        dp = 1'b0; bad = 1'b0; nwait = 0;
      end else begin
        if (dp) begin
          if (m_rdy) begin
            if (sb.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_completion: data phase ended with no expected response");
            end else begin
              e = sb.pop_front();
              check({e.name, "_waits"}, 32'(nwait), 32'(e.waits));
              check({e.name, "_resp"}, {31'd0, m_resp}, {31'd0, e.resp});
              if (bad) check({e.name, "_resp_in_wait"}, {31'd0, !e.resp}, {31'd0, e.resp});
              if (e.rd) check({e.name, "_rdata"}, m_rdata, e.data);
            end
            dp = 1'b0; bad = 1'b0; nwait = 0;
          end else begin
            nwait++;
            if (sb.size() > 0 && m_resp !== sb[0].resp) bad = 1'b1;
          end
        end
        if (m_rdy && hsel_cmd && htrans[1]) dp = 1'b1;
      end
    end
  end

  initial begin : stimulus
    #3 HRESETn = 1'b0;
    #4;
    check("rst_hreadyout0", {31'd0, hro0}, 32'd1);
    check("rst_hresp0", {31'd0, hresp0}, {31'd0, HRESP_OKAY});
    check("rst_hrdata0", hrdata0, 32'h0);
    check("rst_hreadyout1", {31'd0, hro1}, 32'd1);
    check("rst_hrdata1", hrdata1, 32'h0);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    sync();

    // Zero wait states, pipelined master.
    dut_sel = 1'b0;
    issue(1, 32'h10, HSIZE_WORD, 32'hDEAD_BEEF, '0, 0, 1, "wr_10");
    issue(0, 32'h10, HSIZE_WORD, '0, 32'hDEAD_BEEF, 0, 1, "rd_10");
    issue(1, 32'h10, HSIZE_WORD, 32'h1122_3344, '0, 0, 1, "wr_10_pre");
    issue(1, 32'h13, HSIZE_BYTE, 32'hAA00_0000, '0, 0, 1, "wr_byte_13");
    issue(0, 32'h10, HSIZE_WORD, '0, 32'hAA22_3344, 0, 1, "rd_byte_merge");
    issue(1, 32'h18, HSIZE_WORD, 32'h0000_0000, '0, 0, 1, "wr_18_clr");
    issue(1, 32'h1A, HSIZE_HALF, 32'hBEEF_0000, '0, 0, 1, "wr_half_1a");
    issue(1, 32'h18, HSIZE_BYTE, 32'h0000_0007, '0, 0, 1, "wr_byte_18");
    issue(0, 32'h18, HSIZE_WORD, '0, 32'hBEEF_0007, 0, 1, "rd_half_merge");
    issue(1, 32'h20, HSIZE_WORD, 32'h0000_0005, '0, 0, 1, "wr_20");
    issue(0, 32'h20, HSIZE_WORD, '0, 32'h0000_0005, 0, 1, "rd_20_b2b");
`ifdef AHB_SRAM_ERROR_EN
    issue(1, 32'h00, HSIZE_WORD, 32'h0BAD_F00D, '0, 0, 1, "wr_00");
    issue(1, 32'h02, HSIZE_WORD, 32'hFFFF_FFFF, '0, 1, 1, "wr_misaligned");
    issue(0, 32'h00, HSIZE_WORD, '0, 32'h0BAD_F00D, 0, 1, "rd_00_unchanged");
    issue(0, 32'h100, HSIZE_WORD, '0, 32'h0BAD_F00D, 1, 1, "rd_out_of_range");
    issue(1, 32'h00, 3'd3, 32'h0000_0000, '0, 1, 1, "wr_size3");
    issue(0, 32'h00, HSIZE_WORD, '0, 32'h0BAD_F00D, 0, 1, "rd_00_after_err");
`else
    issue(1, 32'h100, HSIZE_WORD, 32'hCAFE_F00D, '0, 0, 1, "wr_wrap_100");
    issue(0, 32'h00, HSIZE_WORD, '0, 32'hCAFE_F00D, 0, 1, "rd_wrap_00");
    issue(1, 32'h26, HSIZE_WORD, 32'h1234_5678, '0, 0, 1, "wr_misaligned_26");
    issue(0, 32'h24, HSIZE_WORD, '0, 32'h1234_5678, 0, 1, "rd_aligned_24");
    issue(1, 32'h28, 3'd3, 32'h89AB_CDEF, '0, 0, 1, "wr_size3_28");
    issue(0, 32'h28, HSIZE_WORD, '0, 32'h89AB_CDEF, 0, 1, "rd_size3_28");
`endif
    wait_done();

    // BUSY with HSEL high is not an access.
    hsel_cmd = 1'b1;
    htrans   = HTRANS_BUSY;
    repeat (2) @(negedge HCLK);
    check("busy_hreadyout", {31'd0, hro0}, 32'd1);
    check("busy_hresp", {31'd0, hresp0}, {31'd0, HRESP_OKAY});
    sync();
    hsel_cmd = 1'b0;
    htrans   = HTRANS_IDLE;
    sync();

    // Three wait states.
    dut_sel = 1'b1;
    sync();
    issue(1, 32'h40, HSIZE_WORD, 32'hA5A5_5A5A, '0, 0, 1, "ws3_wr_40");
    issue(0, 32'h40, HSIZE_WORD, '0, 32'hA5A5_5A5A, 0, 1, "ws3_rd_40");
    issue(1, 32'h44, HSIZE_WORD, 32'h1357_9BDF, '0, 0, 1, "ws3_wr_44");
    issue(0, 32'h44, HSIZE_WORD, '0, 32'h1357_9BDF, 0, 1, "ws3_rd_44");
    wait_done();

    // Reset asserted while a write sits in WAIT.
    issue(1, 32'h44, HSIZE_WORD, 32'hFFFF_FFFF, '0, 0, 0, "ws3_wr_killed");
    @(negedge HCLK);
    check("wait_before_reset", {31'd0, hro1}, 32'd0);
    #2 HRESETn = 1'b0;
    #1;
    check("midrst_hreadyout", {31'd0, hro1}, 32'd1);
    check("midrst_hresp", {31'd0, hresp1}, {31'd0, HRESP_OKAY});
    check("midrst_hrdata", hrdata1, 32'h0);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    sync();
    issue(0, 32'h44, HSIZE_WORD, '0, 32'h1357_9BDF, 0, 1, "rd_44_after_rst");
    wait_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

endmodule
